// File: rtl/div_seq64.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock from an a + ~b + 1 trial subtraction.
// Optional macro DIV_EARLY_OUT_EN: finish at acceptance when |dividend| < |divisor|.
module div_seq64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 32'sd1);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return neg_w(v);
    end else begin
      return v;
    end
  endfunction

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             accept_s;
  logic             dvs_zero_s;
  logic             early_s;
  logic [WIDTH-1:0] dvd_abs_s;
  logic [WIDTH-1:0] dvs_abs_s;
  logic             q_neg_s;
  logic             r_neg_s;
  logic [WIDTH-1:0] shift_lo_s;
  logic [WIDTH-1:0] diff_s;
  logic             c_lo_s;
  logic             carry_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  // Acceptance decode and operand preparation.
  always_comb begin
    accept_s   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    dvs_zero_s = (divisor == ZERO_W);
    dvd_abs_s  = abs_w(dividend, is_signed);
    dvs_abs_s  = abs_w(divisor, is_signed);
    q_neg_s    = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    r_neg_s    = is_signed & dividend[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
    early_s    = !dvs_zero_s && (dvd_abs_s < dvs_abs_s);
`else
    early_s    = 1'b0;
`endif
  end

  // One restoring step; the bit shifted out of rem acts as the 65th bit of the trial subtraction.
  always_comb begin
    shift_lo_s        = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    {c_lo_s, diff_s}  = {1'b0, shift_lo_s} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    carry_s           = rem_q[WIDTH-1] | c_lo_s;
    rem_d             = shift_lo_s;
    if (carry_s) begin
      rem_d = diff_s;
    end else begin
      rem_d = shift_lo_s;
    end
    quo_d     = {quo_q[WIDTH-2:0], carry_s};
    quo_fix_d = quo_q;
    rem_fix_d = rem_q;
    if (q_neg_q) begin
      quo_fix_d = neg_w(quo_q);
    end else begin
      quo_fix_d = quo_q;
    end
    if (r_neg_q) begin
      rem_fix_d = neg_w(rem_q);
    end else begin
      rem_fix_d = rem_q;
    end
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= ZERO_W;
      quo_q       <= ZERO_W;
      dvs_q       <= ZERO_W;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= ZERO_W;
      remainder_q <= ZERO_W;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            quo_q   <= dvd_abs_s;
            dvs_q   <= dvs_abs_s;
            rem_q   <= ZERO_W;
            cnt_q   <= {CW{1'b0}};
            q_neg_q <= q_neg_s;
            r_neg_q <= r_neg_s;
            dbz_q   <= 1'b0;
            if (dvs_zero_s) begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= ONES_W;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else if (early_s) begin
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= ZERO_W;
              remainder_q <= dividend;
            end else begin
              state_q <= ST_ITER;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_FIX;
          end else begin
            state_q <= ST_ITER;
          end
        end
        ST_FIX: begin
          quotient_q  <= quo_fix_d;
          remainder_q <= rem_fix_d;
          state_q     <= ST_DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq64.sv
// Self-checking bench for div_seq64: scoreboard of expected results popped on each done pulse.
module tb_div_seq64;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_seq64 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mag(input logic sgn, input logic [W-1:0] v);
    if (sgn && v[W-1]) return 64'd0 - v;
    return v;
  endfunction

  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] ua, ub, q, r;
    if (b == 64'd0) begin
      e.q = {W{1'b1}}; e.r = a; e.dbz = 1'b1;
      return e;
    end
    ua = mag(sgn, a);
    ub = mag(sgn, b);
    q  = ua / ub;
    r  = ua % ub;
    if (sgn && (a[W-1] ^ b[W-1])) q = 64'd0 - q;
    if (sgn && a[W-1]) r = 64'd0 - r;
    e.q = q; e.r = r; e.dbz = 1'b0;
    return e;
  endfunction

  function automatic int exp_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 64'd0) return 0;
`ifdef DIV_EARLY_OUT_EN
    if (mag(sgn, a) < mag(sgn, b)) return 0;
`endif
    return W + 1;
  endfunction

  // Scoreboard monitor: every done pulse pops one expected result.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected_done: got done=1, required no pending result");
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (quotient !== mon_e.q) begin
          n_fail++; $display("FAIL quotient: got %h, required %h", quotient, mon_e.q);
        end
        n_checks++;
        if (remainder !== mon_e.r) begin
          n_fail++; $display("FAIL remainder: got %h, required %h", remainder, mon_e.r);
        end
        n_checks++;
        if (div_by_zero !== mon_e.dbz) begin
          n_fail++; $display("FAIL div_by_zero: got %b, required %b", div_by_zero, mon_e.dbz);
        end
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL busy_at_done: got %b, required 0", busy);
        end
      end
    end
  end

  task automatic drive_start(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges from the current sample point until done, bounded; -1 on timeout.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 0; busy_cyc = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
      edges++;
    end
    if (done !== 1'b1) edges = -1;
  endtask

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, output int lat, output int bc);
    sb_q.push_back(e);
    drive_start(sgn, a, b);
    wait_done(lat, bc);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = 64'd0; divisor = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_checks++; if (quotient !== 64'd0) begin n_fail++; $display("FAIL reset_quotient: got %h, required 0", quotient); end
    n_checks++; if (remainder !== 64'd0) begin n_fail++; $display("FAIL reset_remainder: got %h, required 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b, required 0", div_by_zero); end
  endtask

  task automatic test_unsigned;
    int lat, bc;
    logic [W-1:0] a, b;
    run_op(1'b0, 64'd100, 64'd7, '{q: 64'd14, r: 64'd2, dbz: 1'b0}, lat, bc);
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL u100_7_latency: got %0d, required %0d", lat, W + 1); end
    n_checks++; if (bc !== W + 1) begin n_fail++; $display("FAIL u100_7_busy_cycles: got %0d, required %0d", bc, W + 1); end
    for (int i = 0; i < 4; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()} >> $urandom_range(0, 60);
      if (b == 64'd0) b = 64'd3;
      run_op(1'b0, a, b, model(1'b0, a, b), lat, bc);
      n_checks++;
      if (lat !== exp_lat(1'b0, a, b)) begin
        n_fail++; $display("FAIL urand_latency: got %0d, required %0d", lat, exp_lat(1'b0, a, b));
      end
    end
    a = {W{1'b1}};
    b = {W{1'b1}};
    run_op(1'b0, a, b, '{q: 64'd1, r: 64'd0, dbz: 1'b0}, lat, bc);
    a = 64'd5;
    run_op(1'b0, 64'd5, b, model(1'b0, a, b), lat, bc);
  endtask

  task automatic test_signed;
    int lat, bc;
    logic [W-1:0] a, b;
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           '{q: 64'hFFFF_FFFF_FFFF_FFFD, r: 64'hFFFF_FFFF_FFFF_FFFF, dbz: 1'b0}, lat, bc);
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL sneg7_2_latency: got %0d, required %0d", lat, W + 1); end
    run_op(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           '{q: 64'hFFFF_FFFF_FFFF_FFFD, r: 64'd1, dbz: 1'b0}, lat, bc);
    for (int i = 0; i < 4; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()} >> $urandom_range(20, 62);
      if (b == 64'd0) b = 64'd5;
      if (i[0]) b = 64'd0 - b;
      run_op(1'b1, a, b, model(1'b1, a, b), lat, bc);
      n_checks++;
      if (bc !== ((exp_lat(1'b1, a, b) == 0) ? 0 : W + 1)) begin
        n_fail++; $display("FAIL srand_busy_cycles: got %0d, required %0d", bc, (exp_lat(1'b1, a, b) == 0) ? 0 : W + 1);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int lat, bc;
    run_op(1'b0, 64'h1234, 64'd0, '{q: {W{1'b1}}, r: 64'h1234, dbz: 1'b1}, lat, bc);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dbz_latency: got %0d, required 0", lat); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL dbz_busy_cycles: got %0d, required 0", bc); end
    sb_q.push_back('{q: 64'd3, r: 64'd0, dbz: 1'b0});
    drive_start(1'b0, 64'd9, 64'd3);
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear: got %b, required 0", div_by_zero); end
    n_checks++; if (quotient !== {W{1'b1}}) begin n_fail++; $display("FAIL dbz_result_hold: got %h, required all ones", quotient); end
    wait_done(lat, bc);
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL after_dbz_latency: got %0d, required %0d", lat, W + 1); end
  endtask

  task automatic test_overflow;
    int lat, bc;
    run_op(1'b1, 64'h8000_0000_0000_0000, {W{1'b1}},
           '{q: 64'h8000_0000_0000_0000, r: 64'd0, dbz: 1'b0}, lat, bc);
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL ovf_latency: got %0d, required %0d", lat, W + 1); end
    run_op(1'b1, 64'd5, 64'h8000_0000_0000_0000, '{q: 64'd0, r: 64'd5, dbz: 1'b0}, lat, bc);
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'd3,
           model(1'b1, 64'h8000_0000_0000_0000, 64'd3), lat, bc);
  endtask

  task automatic test_ignore_restart;
    int lat, bc;
    sb_q.push_back('{q: 64'd100, r: 64'd0, dbz: 1'b0});
    drive_start(1'b0, 64'd1000, 64'd10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b, required 1", busy); end
    is_signed = 1'b1; dividend = 64'd77; divisor = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    n_checks++; if (lat !== W + 1 - 10) begin n_fail++; $display("FAIL restart_latency: got %0d, required %0d", lat, W + 1 - 10); end
  endtask

  task automatic test_midreset;
    int lat, bc;
    sb_q.push_back('{q: 64'd17636, r: 64'd4, dbz: 1'b0});
    drive_start(1'b0, 64'd123456, 64'd7);
    repeat (29) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b, required 0", done); end
    n_checks++; if (quotient !== 64'd0) begin n_fail++; $display("FAIL midrst_quotient: got %h, required 0", quotient); end
    n_checks++; if (remainder !== 64'd0) begin n_fail++; $display("FAIL midrst_remainder: got %h, required 0", remainder); end
    sb_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b, required 0", busy); end
    run_op(1'b0, 64'd9, 64'd3, '{q: 64'd3, r: 64'd0, dbz: 1'b0}, lat, bc);
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL post_rst_latency: got %0d, required %0d", lat, W + 1); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, bc;
    sb_q.push_back('{q: 64'd10, r: 64'd0, dbz: 1'b0});
    sb_q.push_back('{q: 64'd10, r: 64'd0, dbz: 1'b0});
    @(negedge clk);
    is_signed = 1'b0; dividend = 64'd50; divisor = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat1, bc);
    n_checks++; if (lat1 !== W + 1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d, required %0d", lat1, W + 1); end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_reaccept: got done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    wait_done(lat2, bc);
    n_checks++; if (lat2 + 1 !== W + 2) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d, required %0d", lat2 + 1, W + 2); end
  endtask

  task automatic test_early_out;
    int lat, bc;
    run_op(1'b0, 64'd3, 64'd10, '{q: 64'd0, r: 64'd3, dbz: 1'b0}, lat, bc);
    n_checks++;
    if (lat !== exp_lat(1'b0, 64'd3, 64'd10)) begin
      n_fail++; $display("FAIL early_latency: got %0d, required %0d", lat, exp_lat(1'b0, 64'd3, 64'd10));
    end
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10,
           '{q: 64'd0, r: 64'hFFFF_FFFF_FFFF_FFFD, dbz: 1'b0}, lat, bc);
    n_checks++;
    if (lat !== exp_lat(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10)) begin
      n_fail++; $display("FAIL early_signed_latency: got %0d, required %0d", lat, exp_lat(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_ignore_restart();
    test_midreset();
    test_back_to_back();
    test_early_out();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
